// File: rtl/fifo_wr_arb_pkg.sv
// Shared types and helpers for the round-robin FIFO write arbiter.
package fifo_wr_arb_pkg;

  typedef enum logic {IDLE, BURST} state_e;

  localparam int unsigned BEAT_W = 8;

  // Index width for an n-entry requester vector; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// Round-robin picker: first set bit of req searching upward from start, modulo NREQ.
module rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   start,
  output logic            valid,
  output logic [IW-1:0]   idx
);

  logic [IW-1:0] cand;

  // Scan farthest offset first so the nearest set bit is the last one written.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand = IW'((int'(start) + i) % NREQ);
      if (req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin write arbiter sharing one FIFO write port among NREQ producers.
// Define FIFO_WR_ARB_CNT_EN to add per-requester accepted-word counters on wcnt.
module fifo_wr_arb
  import fifo_wr_arb_pkg::*;
#(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned DW        = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*DW-1:0]        din,
  output logic [NREQ-1:0]           ack,
  output logic                      fifo_wr,
  output logic [DW-1:0]             fifo_din,
  input  logic                      fifo_full,
  output logic                      busy,
  output logic [idx_w(NREQ)-1:0]    owner
`ifdef FIFO_WR_ARB_CNT_EN
  ,
  output logic [NREQ*16-1:0]        wcnt
`endif
);

  localparam int unsigned OW = idx_w(NREQ);

  state_e            state_q;
  logic [OW-1:0]     owner_q, rr_ptr_q;
  logic [BEAT_W-1:0] beat_q;

  logic [OW-1:0]     owner_inc, pick_start, pick_idx;
  logic              pick_valid;
  logic              wr_ok, burst_end;
  logic [DW-1:0]     owner_word;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (OW)
  ) u_rr_pick (
    .req   (req),
    .start (pick_start),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    owner_inc  = (owner_q == OW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
    pick_start = (state_q == IDLE) ? rr_ptr_q : owner_inc;
    // rst_n gates the write so a word offered during reset is neither written nor acked.
    wr_ok      = rst_n && (state_q == BURST) && req[owner_q] && !fifo_full;
    burst_end  = (state_q == BURST) &&
                 (!req[owner_q] || (wr_ok && ((beat_q + 1'b1) == BEAT_W'(MAX_BURST))));
    owner_word = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner_q == OW'(i)) owner_word = din[i*DW +: DW];
    end
    ack = '0;
    for (int i = 0; i < NREQ; i++) begin
      ack[i] = wr_ok && (owner_q == OW'(i));
    end
    fifo_wr  = wr_ok;
    fifo_din = wr_ok ? owner_word : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      beat_q   <= '0;
      rr_ptr_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            owner_q <= pick_idx;
            beat_q  <= '0;
            state_q <= BURST;
          end
        end
        BURST: begin
          if (burst_end) begin
            rr_ptr_q <= owner_inc;
            beat_q   <= '0;
            if (pick_valid) owner_q <= pick_idx;
            else            state_q <= IDLE;
          end else if (wr_ok) begin
            beat_q <= beat_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy  = (state_q == BURST);
  assign owner = owner_q;

`ifdef FIFO_WR_ARB_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wcnt <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (ack[i]) wcnt[i*16 +: 16] <= wcnt[i*16 +: 16] + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed self-checking bench for fifo_wr_arb (NREQ=4, DW=8, MAX_BURST=4).
module tb_fifo_wr_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] din;
  logic [3:0]  ack;
  logic        fifo_wr;
  logic [7:0]  fifo_din;
  logic        fifo_full;
  logic        busy;
  logic [1:0]  owner;
`ifdef FIFO_WR_ARB_CNT_EN
  logic [63:0] wcnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_wr_arb #(
    .NREQ      (4),
    .DW        (8),
    .MAX_BURST (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .din       (din),
    .ack       (ack),
    .fifo_wr   (fifo_wr),
    .fifo_din  (fifo_din),
    .fifo_full (fifo_full),
    .busy      (busy),
    .owner     (owner)
`ifdef FIFO_WR_ARB_CNT_EN
    ,
    .wcnt      (wcnt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 2 units later.
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req       = '0;
    din       = '0;
    fifo_full = 1'b0;
    next();
    next();
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset state
    do_reset();
    #2;
    chk("rst busy", busy, 0);
    chk("rst owner", owner, 0);
    chk("rst fifo_wr", fifo_wr, 0);
    chk("rst ack", ack, 0);

    // Sole requester 0, six words, re-grant at beat 4 without a bubble
    req = 4'b0001;
    din[7:0] = 8'hA0;
    #2;
    chk("idle no write", fifo_wr, 0);
    next();
    for (int k = 0; k < 6; k++) begin
      #2;
      chk("solo ack", ack, 4'b0001);
      chk("solo din", fifo_din, 8'hA0 + k);
      chk("solo busy", busy, 1);
      next();
      din[7:0] = din[7:0] + 8'd1;
      if (k == 5) req = 4'b0000;
    end
    #2;
    chk("solo dead wr", fifo_wr, 0);
    chk("solo dead busy", busy, 1);
    next();
    #2;
    chk("solo idle", busy, 0);

    // All four requesting: grants 0,1,2,3,0 with four beats each
    do_reset();
    req = 4'b1111;
    din = {8'h13, 8'h12, 8'h11, 8'h10};
    #2;
    chk("rr idle wr", fifo_wr, 0);
    next();
    for (int n = 0; n < 20; n++) begin
      #2;
      chk("rr owner", owner, (n / 4) % 4);
      chk("rr ack", ack, 64'd1 << ((n / 4) % 4));
      chk("rr din", fifo_din, 8'h10 + (n / 4) % 4);
      chk("rr wr", fifo_wr, 1);
      next();
    end

    // Owner 1 stalled by fifo_full for three cycles; beat count frozen
    do_reset();
    req = 4'b0010;
    din[15:8] = 8'h50;
    next();
    #2;
    chk("full pre ack", ack, 4'b0010);
    chk("full pre din", fifo_din, 8'h50);
    next();
    din[15:8]  = 8'h51;
    din[23:16] = 8'h70;
    req        = 4'b0110;
    fifo_full  = 1'b1;
    for (int s = 0; s < 3; s++) begin
      #2;
      chk("full wr", fifo_wr, 0);
      chk("full ack", ack, 0);
      chk("full din", fifo_din, 0);
      chk("full owner", owner, 1);
      next();
    end
    fifo_full = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #2;
      chk("resume ack", ack, 4'b0010);
      chk("resume din", fifo_din, 8'h51 + k);
      next();
      din[15:8] = din[15:8] + 8'd1;
    end
    req = 4'b0100;
    #2;
    chk("handover owner", owner, 2);
    chk("handover ack", ack, 4'b0100);
    chk("handover din", fifo_din, 8'h70);

    // Owner 0 drops req after two beats while req[2] waits
    do_reset();
    req = 4'b0001;
    din[7:0] = 8'h30;
    next();
    #2;
    chk("drop b0 ack", ack, 4'b0001);
    chk("drop b0 din", fifo_din, 8'h30);
    next();
    din[7:0]   = 8'h31;
    din[23:16] = 8'h90;
    req        = 4'b0101;
    #2;
    chk("drop b1 ack", ack, 4'b0001);
    chk("drop b1 din", fifo_din, 8'h31);
    next();
    req = 4'b0100;
    #2;
    chk("drop dead wr", fifo_wr, 0);
    chk("drop dead ack", ack, 0);
    chk("drop dead busy", busy, 1);
    next();
    #2;
    chk("drop new owner", owner, 2);
    chk("drop new ack", ack, 4'b0100);
    chk("drop new din", fifo_din, 8'h90);

    // Reset asserted during owner 3's second beat
    do_reset();
    req = 4'b1000;
    din[31:24] = 8'hC0;
    next();
    #2;
    chk("mid b0 ack", ack, 4'b1000);
    next();
    din[31:24] = 8'hC1;
    rst_n = 1'b0;
    #2;
    chk("mid rst wr", fifo_wr, 0);
    chk("mid rst ack", ack, 0);
    chk("mid rst din", fifo_din, 0);
    next();
    rst_n = 1'b1;
    req = 4'b1010;
    din[15:8] = 8'hB0;
    #2;
    chk("post rst busy", busy, 0);
    chk("post rst owner", owner, 0);
    chk("post rst wr", fifo_wr, 0);
    next();
    #2;
    chk("post rst grant", owner, 1);
    chk("post rst ack", ack, 4'b0010);
    chk("post rst din", fifo_din, 8'hB0);

`ifdef FIFO_WR_ARB_CNT_EN
    // Accepted-word counters: 10 words from requester 0, 7 from requester 2
    begin
      int sent;
      do_reset();
      #2;
      chk("cnt rst", wcnt, 0);
      sent = 0;
      req  = 4'b0001;
      for (int c = 0; c < 40 && sent < 10; c++) begin
        #2;
        if (ack[0]) sent++;
        next();
        if (sent == 10) req = 4'b0000;
      end
      chk("cnt req0 sent", sent, 10);
      sent = 0;
      req  = 4'b0100;
      for (int c = 0; c < 40 && sent < 7; c++) begin
        #2;
        if (ack[2]) sent++;
        next();
        if (sent == 7) req = 4'b0000;
      end
      chk("cnt req2 sent", sent, 7);
      next();
      next();
      #2;
      chk("cnt slice0", wcnt[15:0], 10);
      chk("cnt slice1", wcnt[31:16], 0);
      chk("cnt slice2", wcnt[47:32], 7);
      chk("cnt slice3", wcnt[63:48], 0);
      do_reset();
      #2;
      chk("cnt cleared", wcnt, 0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
